// File: rtl/commit_trace_buffer_if.sv
// Commit-capture and drain port bundle for commit_trace_buffer.
// The master drives commits, control and pops; the slave is the buffer.
interface commit_trace_buffer_if #(
  parameter int DATA_W  = 32,
  parameter int RD_W    = 4,
  parameter int DEPTH   = 16,
  parameter int STAMP_W = 16,
  parameter int OVF_W   = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              commit_valid;
  logic [DATA_W-1:0] commit_pc;
  logic [DATA_W-1:0] commit_instr;
  logic [DATA_W-1:0] commit_data;
  logic [RD_W-1:0]   commit_rd;
  logic              commit_wb;
  logic              arm;
  logic              mode;
  logic [DATA_W-1:0] trig_pc;
  logic [CNT_W-1:0]  post_count;
  logic              pop;

  logic               out_valid;
  logic [STAMP_W-1:0] out_stamp;
  logic [DATA_W-1:0]  out_pc;
  logic [DATA_W-1:0]  out_instr;
  logic [DATA_W-1:0]  out_data;
  logic [RD_W-1:0]    out_rd;
  logic               out_wb;
  logic [CNT_W-1:0]   count;
  logic [OVF_W-1:0]   overflow_cnt;
  logic [1:0]         state;
  logic               triggered;

  modport master (
    output commit_valid, commit_pc, commit_instr, commit_data, commit_rd, commit_wb,
    output arm, mode, trig_pc, post_count, pop,
    input  out_valid, out_stamp, out_pc, out_instr, out_data, out_rd, out_wb,
    input  count, overflow_cnt, state, triggered
  );

  modport slave (
    input  commit_valid, commit_pc, commit_instr, commit_data, commit_rd, commit_wb,
    input  arm, mode, trig_pc, post_count, pop,
    output out_valid, out_stamp, out_pc, out_instr, out_data, out_rd, out_wb,
    output count, overflow_cnt, state, triggered
  );
endinterface

// File: rtl/commit_trace_buffer.sv
// Retirement trace buffer: captures committed instructions into a FWFT queue,
// either stop-when-full (FIFO mode) or circular with a PC trigger and post-count.
module commit_trace_buffer #(
  parameter int DATA_W  = 32,
  parameter int RD_W    = 4,
  parameter int DEPTH   = 16,
  parameter int STAMP_W = 16,
  parameter int OVF_W   = 16
) (
  input logic                  clk,
  input logic                  reset,
  commit_trace_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = STAMP_W + 3 * DATA_W + RD_W + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, POST = 2'd2, FROZEN = 2'd3} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   post_q, post_d, left_q, left_d;
  logic [OVF_W-1:0]   ovf_q, ovf_d;
  logic               trig_q, trig_d, mode_q, mode_d;
  logic [DATA_W-1:0]  trig_pc_q, trig_pc_d;
  logic [STAMP_W-1:0] stamp_q;
  logic [ENT_W-1:0]   mem_q [DEPTH];
  logic [ENT_W-1:0]   head_ent;

  logic capture_en, full, pop_eff, take, push, overwrite, drop, trig_hit;
  logic [CNT_W-1:0] post_clamped;

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    if (bus.arm) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN:     if (trig_hit) state_d = (post_q == '0) ? FROZEN : POST;
        POST:    if (push && left_q == CNT_W'(1)) state_d = FROZEN;
        default: state_d = state_q;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    capture_en = (state_q == RUN) || (state_q == POST);
  end

  always_comb begin
    full         = (count_q == CNT_W'(DEPTH));
    pop_eff      = bus.pop && (count_q != '0);
    take         = capture_en && bus.commit_valid && !bus.arm;
    // Trigger mode always stores; FIFO mode needs room or a simultaneous pop.
    push         = take && (mode_q || !full || pop_eff);
    drop         = take && !push;
    overwrite    = push && full && !pop_eff;
    trig_hit     = take && mode_q && (state_q == RUN) && (bus.commit_pc == trig_pc_q);
    post_clamped = (bus.post_count > CNT_W'(DEPTH - 1)) ? CNT_W'(DEPTH - 1) : bus.post_count;
  end

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    trig_d    = trig_q;
    mode_d    = mode_q;
    trig_pc_d = trig_pc_q;
    post_d    = post_q;
    left_d    = left_q;
    if (bus.arm) begin
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      ovf_d     = '0;
      trig_d    = 1'b0;
      mode_d    = bus.mode;
      trig_pc_d = bus.trig_pc;
      post_d    = post_clamped;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop_eff || overwrite) head_d = head_q + PTR_W'(1);
      if (push && !pop_eff && !full) count_d = count_q + CNT_W'(1);
      else if (pop_eff && !push)     count_d = count_q - CNT_W'(1);
      if (drop && ovf_q != {OVF_W{1'b1}}) ovf_d = ovf_q + OVF_W'(1);
      if (trig_hit) begin
        trig_d = 1'b1;
        left_d = post_q;
      end else if (state_q == POST && push) begin
        left_d = left_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      ovf_q     <= '0;
      trig_q    <= 1'b0;
      mode_q    <= 1'b0;
      trig_pc_q <= '0;
      post_q    <= '0;
      left_q    <= '0;
      stamp_q   <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      trig_q    <= trig_d;
      mode_q    <= mode_d;
      trig_pc_q <= trig_pc_d;
      post_q    <= post_d;
      left_q    <= left_d;
      stamp_q   <= stamp_q + STAMP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= {stamp_q, bus.commit_pc, bus.commit_instr, bus.commit_data,
                        bus.commit_rd, bus.commit_wb};
    end
  end

  // Gate the head so every out_* reads zero while empty, including after reset.
  assign head_ent      = bus.out_valid ? mem_q[head_q] : '0;
  assign bus.out_valid = (count_q != '0);
  assign {bus.out_stamp, bus.out_pc, bus.out_instr, bus.out_data, bus.out_rd, bus.out_wb} = head_ent;
  assign bus.count        = count_q;
  assign bus.overflow_cnt = ovf_q;
  assign bus.state        = state_q;
  assign bus.triggered    = trig_q;
endmodule

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Parametrised retirement trace buffer for the SimpleRisc 5-stage pipeline. It sits beside the writeback stage and captures every committed instruction as one entry: PC, instruction word, destination register, writeback flag, writeback data and a cycle stamp. Entries drain through a first-word-fall-through pop port. It supports a stop-when-full FIFO mode and a circular trigger mode that freezes a fixed number of commits after a PC match, replacing cycle-by-cycle `$display` tracing with hardware capture.

## Interface
- `DATA_W`, 32, width of PC, instruction and writeback data.
- `RD_W`, 4, width of the destination register index.
- `DEPTH`, 16, number of entries; power of two, at least 2.
- `STAMP_W`, 16, width of the cycle stamp and free-running cycle counter.
- `OVF_W`, 16, width of the dropped-commit counter.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `commit_valid`  in  1  one instruction retires this cycle.
- `commit_pc`, `commit_instr`, `commit_data`  in  DATA_W each  retiring PC, instruction word and writeback data.
- `commit_rd`  in  RD_W  destination register.
- `commit_wb`  in  1  writeback enable of the retiring instruction.
- `arm`  in  1  single-cycle pulse that clears the buffer and starts capture.
- `mode`  in  1  0 = FIFO mode, 1 = trigger mode; sampled only on `arm`.
- `trig_pc`  in  DATA_W  trigger PC; sampled on `arm`.
- `post_count`  in  $clog2(DEPTH)+1  commits kept after the trigger; sampled on `arm`, clamped to DEPTH-1.
- `pop`  in  1  consume the head entry.
- `out_valid`  out  1  head entry present.
- `out_stamp`  out  STAMP_W  cycle stamp of the head entry.
- `out_pc`, `out_instr`, `out_data`  out  DATA_W each  PC, instruction word and writeback data of the head entry.
- `out_rd`  out  RD_W  destination register of the head entry.
- `out_wb`  out  1  writeback flag of the head entry.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow_cnt`  out  OVF_W  commits dropped in FIFO mode; saturates at all-ones.
- `state`  out  2  IDLE=0, RUN=1, POST=2, FROZEN=3.
- `triggered`  out  1  high from the trigger commit until the next `arm` or reset.

## Operation
**States**
- IDLE: no capture. Pops are allowed.
- RUN
  - FIFO mode: a push occurs on `commit_valid`. It is dropped when `count==DEPTH` and no pop occurs in the same cycle.
  - Trigger mode: circular capture. A push when full overwrites the oldest entry and advances the head; `count` stays at DEPTH and `overflow_cnt` is unchanged.
  - Trigger mode only: a commit with `commit_pc==trig_pc` is stored, sets `triggered`, and moves the state to POST. If `post_count==0` the state moves to FROZEN instead.
- POST: circular capture continues. A down-counter loads `post_count` on the trigger and decrements per stored commit. The commit that brings it to 0 is stored, then the state moves to FROZEN.
- FROZEN: no pushes. Commits are ignored and not counted as overflow. Pops are allowed. Exit is by `arm` or reset only.

**Arm**
- `arm` in any state clears head, tail, `count`, `overflow_cnt` and `triggered`, latches `mode`, `trig_pc` and `post_count`, and moves to RUN.
- A commit in the same cycle as `arm` is not stored.

**Pop**
- A pop with `out_valid==0` is ignored.
- Push and pop in the same cycle: both take effect and `count` is unchanged. A full FIFO-mode buffer therefore does not drop the commit.

**Stamp and pointers**
- The cycle counter resets to 0, increments every cycle and wraps modulo 2^STAMP_W.
- An entry's stamp is the counter value in its capture cycle.
- Pointers are $clog2(DEPTH) bits and wrap naturally.

## Timing
- Reset (async assert) gives: state IDLE, `count` 0, `out_valid` 0, all `out_*` 0, `overflow_cnt` 0, `triggered` 0, cycle counter 0.
- Reset mid-capture discards all entries.
- Capture latency is one edge: a commit sampled at edge k gives `out_valid` high after edge k when the buffer was empty.
- `out_*` are read combinationally from the head entry (FWFT). They are valid while `out_valid` is high and advance one edge after a pop.
- `count`, `state`, `triggered` and `overflow_cnt` are registered and update on the same edge as the event that changes them.

## Test plan
- Bench runs at DEPTH=4. Reset, then `arm` with mode 0, then commits PC 0x00,0x04,0x08 on consecutive cycles → `count`=3 and the head is PC 0x00. Three pops return 0x00,0x04,0x08 with stamps increasing by 1, and `out_valid` then goes 0.
- FIFO mode: 6 commits with no pops → `count`=4, `overflow_cnt`=2, entries hold the first 4 PCs. A push+pop in the same cycle while full → `overflow_cnt` unchanged.
- Trigger mode, `trig_pc`=0x20, `post_count`=2, commits PC 0x10..0x40 step 4 → FROZEN after 0x28. The buffer holds 0x1C,0x20,0x24,0x28, `triggered`=1, and later commits are ignored.
- Trigger mode, `post_count`=0, trigger on the first commit 0x20 → FROZEN next edge, `count`=1.
- Assert `reset` low while in POST with `count`=3 → all outputs return to their reset values immediately, state IDLE. A re-`arm` resumes capture normally.
- Cycle counter with STAMP_W=4: commits at counter 15 then the next cycle → stamps 0xF and 0x0.
